// File: rtl/ram_1rw1r.sv
// Dual-port SRAM model: port 0 is read/write with byte enables, port 1 is read-only.
// Both ports have registered read data. An optional sequencer zeroes the array after reset.
module ram_1rw1r #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DEPTH          = 128,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit BYPASS         = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    VPWR,
    input  logic                    VGND,
    input  logic                    EN0,
    input  logic [ADDR_WIDTH-1:0]   A0,
    input  logic [DATA_WIDTH-1:0]   Di0,
    input  logic [DATA_WIDTH/8-1:0] WE0,
    output logic [DATA_WIDTH-1:0]   Do0,
    input  logic                    EN1,
    input  logic [ADDR_WIDTH-1:0]   A1,
    output logic [DATA_WIDTH-1:0]   Do1,
    output logic                    BUSY
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   do0_q, do0_d, do1_q, do1_d;
    logic                    in0, in1, acc0, acc1, wr0, collide;
    logic [DATA_WIDTH-1:0]   old0, old1, merged;
    logic                    unused_pwr;

    assign unused_pwr = VPWR ^ VGND;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            if (CLEAR_ON_RESET) state_q <= S_CLEAR;
            else                state_q <= S_READY;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter parks on the last word so it never exceeds DEPTH-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            if (cnt_q == LAST) state_d = S_READY;
            else               cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    assign BUSY = busy;

    always_comb begin
        in0    = ({1'b0, A0} < DEPTH_L);
        in1    = ({1'b0, A1} < DEPTH_L);
        old0   = in0 ? mem[A0] : '0;
        old1   = in1 ? mem[A1] : '0;
        merged = old0;
        for (int i = 0; i < LANES; i++) begin
            if (WE0[i]) merged[8*i +: 8] = Di0[8*i +: 8];
        end
        acc0    = !busy && EN0;
        acc1    = !busy && EN1;
        wr0     = acc0 && (|WE0) && in0;
        collide = BYPASS && wr0 && acc1 && (A0 == A1);
        do0_d   = acc0 ? old0 : do0_q;
        do1_d   = acc1 ? (collide ? merged : old1) : do1_q;
    end

    // Array has no reset; writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (RESETn) begin
            if (busy)     mem[cnt_q] <= '0;
            else if (wr0) mem[A0]    <= merged;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            do0_q <= '0;
            do1_q <= '0;
        end else begin
            do0_q <= do0_d;
            do1_q <= do1_d;
        end
    end

    assign Do0 = do0_q;
    assign Do1 = do1_q;
endmodule
